// File: rtl/alu_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_ex_stage_if
// Purpose  : Operand/result handshake bundle for the ALU execute stage.
//            Upstream side: in_valid/in_ready with in_op, in_a, in_b, in_rd.
//            Downstream side: out_valid/out_ready with out_result, out_rd,
//            out_illegal.
//            master modport : issuer/consumer (drives operands and out_ready)
//            slave modport  : the execute stage
// Revision : 1.0 - initial release
// ============================================================================
interface alu_ex_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_ex_stage
// Purpose  : Single-issue ALU execute stage. Single-cycle ops (ADD, SUB, AND,
//            OR, XOR, SLT, SLTU) load the output register on the accept edge.
//            MUL runs a 32-iteration shift-add multiplier and writes back the
//            low 32 bits of the product. Ops 8-15 return 0 with out_illegal.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - alu_ex_stage_if.slave (operand in / result out handshake)
//            busy  - high while a multiply is in flight (FSM not idle)
// Revision : 1.0 - initial release
// ============================================================================
module alu_ex_stage (
    input  logic          clk,
    input  logic          rst_n,
    alu_ex_stage_if.slave bus,
    output logic          busy
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLT  = 4'd5;
    localparam logic [3:0] c_OP_SLTU = 4'd6;
    localparam logic [3:0] c_OP_MUL  = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_MUL_WB = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_out_valid;
    logic [31:0] r_out_result;
    logic [3:0]  r_out_rd;
    logic        r_out_illegal;

    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_count;
    logic [3:0]  r_mul_rd;

    logic        w_out_free;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_is_mul;
    logic        w_load_alu;
    logic        w_load_mul;
    logic [32:0] w_sub;
    logic [31:0] w_alu_result;
    logic        w_alu_illegal;

    // Output register can take new data when empty or being drained this edge.
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_in_ready = rst_n && (r_state == ST_IDLE) && w_out_free;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_is_mul   = (bus.in_op == c_OP_MUL);
    assign w_load_alu = w_accept && !w_is_mul;
    // Accept only happens in IDLE, so the two load sources never collide.
    assign w_load_mul = (r_state == ST_MUL_WB) && w_out_free;

    // a + ~b + 1 with the carry kept: bit 32 is the no-borrow flag for SLTU.
    assign w_sub = {1'b0, bus.in_a} + {1'b0, ~bus.in_b} + 33'd1;

    always_comb begin
        w_alu_result  = 32'd0;
        w_alu_illegal = 1'b0;
        case (bus.in_op)
            c_OP_ADD:  w_alu_result = bus.in_a + bus.in_b;
            c_OP_SUB:  w_alu_result = w_sub[31:0];
            c_OP_AND:  w_alu_result = bus.in_a & bus.in_b;
            c_OP_OR:   w_alu_result = bus.in_a | bus.in_b;
            c_OP_XOR:  w_alu_result = bus.in_a ^ bus.in_b;
            // Differing signs: the negative operand is the smaller one.
            c_OP_SLT:  w_alu_result = {31'd0, (bus.in_a[31] != bus.in_b[31]) ?
                                               bus.in_a[31] : w_sub[31]};
            c_OP_SLTU: w_alu_result = {31'd0, !w_sub[32]};
            c_OP_MUL:  w_alu_result = 32'd0;
            default:   w_alu_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept && w_is_mul) w_state_nxt = ST_MUL;
            ST_MUL:    if (r_count == 5'd31)     w_state_nxt = ST_MUL_WB;
            ST_MUL_WB: if (w_out_free)           w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier: one multiplier bit per cycle, 32 cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 32'd0;
            r_count  <= 5'd0;
            r_mul_rd <= 4'd0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= bus.in_a;
            r_mplier <= bus.in_b;
            r_acc    <= 32'd0;
            r_count  <= 5'd0;
            r_mul_rd <= bus.in_rd;
        end else if (r_state == ST_MUL) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= {r_mcand[30:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
            r_count  <= r_count + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output register: load wins over drain so a simultaneous drain+load
    // keeps out_valid high with the new data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= 32'd0;
            r_out_rd      <= 4'd0;
            r_out_illegal <= 1'b0;
        end else if (w_load_alu) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_alu_result;
            r_out_rd      <= bus.in_rd;
            r_out_illegal <= w_alu_illegal;
        end else if (w_load_mul) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= r_acc;
            r_out_rd      <= r_mul_rd;
            r_out_illegal <= 1'b0;
        end else if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_out_result;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_illegal = r_out_illegal;
    assign busy            = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_ex_stage.md
ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream operand bundle valid.
REQ-005 in_ready  output  1  stage accepts bundle this cycle.
REQ-006 in_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 MUL, 8-15 illegal.
REQ-007 in_a, in_b  input  32 each  operands.
REQ-008 in_rd  input  4  destination register tag, passed through.
REQ-009 out_valid  output  1  registered result valid.
REQ-010 out_ready  input  1  downstream (writeback) accepts result.
REQ-011 out_result  output  32  registered result.
REQ-012 out_rd  output  4  registered destination tag.
REQ-013 out_illegal  output  1  registered; result came from an illegal op.
REQ-014 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, MUL_WB.
REQ-016 in_ready SHALL equal rst_n AND (state==IDLE) AND (!out_valid OR out_ready).
REQ-017 Accept SHALL occur on an edge where in_valid AND in_ready.
REQ-018 Non-MUL accept at edge N: out_result/out_rd/out_illegal loaded and out_valid=1 at edge N, so the result is visible in cycle N+1; throughput SHALL be one op per cycle.
REQ-019 ADD/SUB SHALL wrap modulo 2^32; SUB = a + ~b + 1.
REQ-020 SLT SHALL produce 1 iff signed a<b: when a[31]!=b[31], the result is a[31]; otherwise the result is (a-b)[31]. Upper 31 bits SHALL be 0.
REQ-021 SLTU SHALL produce 1 iff the carry-out of a + ~b + 1 is 0.
REQ-022 Illegal ops SHALL produce out_result=0 and out_illegal=1; legal ops SHALL produce out_illegal=0.
REQ-023 MUL accept at edge N: multiplicand=a, multiplier=b, acc=0, count=0, state->MUL; no output register update.
REQ-024 In MUL, at each edge: if multiplier[0]=1 then acc+=multiplicand (mod 2^32); multiplicand<<=1; multiplier>>=1; count++. After the edge with count==31 (edge N+32), state->MUL_WB.
REQ-025 In MUL_WB, on the first edge with (!out_valid OR out_ready), the output register SHALL load the low 32 bits of acc, out_rd, and out_illegal=0; state->IDLE. The minimum case is edge N+33.
REQ-026 When out_valid AND out_ready at an edge with no new load, out_valid SHALL clear at that edge.
REQ-027 While out_valid AND !out_ready, out_result/out_rd/out_illegal SHALL be held stable.
REQ-028 A drain and a new load on the same edge SHALL yield out_valid=1 with the new data; no bubble, no loss.
REQ-029 in_rd for MUL SHALL be captured at accept and presented with the MUL result.

Reset
REQ-030 On rst_n low, asynchronously: out_valid=0, out_result=0, out_rd=0, out_illegal=0, state=IDLE, acc=0, count=0, busy=0, in_ready=0.
REQ-031 Reset during MUL or MUL_WB SHALL abort the op with no output; the first cycle after release SHALL have in_ready=1.

Verification
REQ-032 ADD a=0x7FFFFFFF, b=1, rd=3 -> next cycle out_valid=1, out_result=0x80000000, out_rd=3.
REQ-033 SLT a=0xFFFFFFFF, b=1 -> 1; SLTU same -> 0; SLT a=0x80000000, b=0x7FFFFFFF -> 1; SLT a=5, b=5 -> 0.
REQ-034 Ten back-to-back ADDs with out_ready=1 -> ten consecutive results, no bubbles. Drop out_ready for 3 cycles -> output held, in_ready=0; on release, no loss or duplication.
REQ-035 MUL a=b=0xFFFFFFFF at edge N, out_ready=1 -> busy and in_ready=0 for 33 cycles; out_result=0x00000001 visible after edge N+33. MUL 7x6 -> 42.
REQ-036 MUL with out_valid held by out_ready=0 at completion -> state stays MUL_WB. Release out_ready -> old result drains and product loads on the same edge.
REQ-037 rst_n low at MUL count 10 -> all outputs 0. In_op=0xF after release -> out_result=0, out_illegal=1.
